// File: rtl/johnson_pkg.sv
// Shared types and the reference Johnson-code decoder used by the phase monitor
// and by the Johnson counter's own self-check.
package johnson_pkg;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    ACQ    = 2'd1,
    LOCKED = 2'd2,
    LOST   = 2'd3
  } lock_state_t;

  localparam int MAX_W     = 16;
  localparam int DEF_WIDTH = 4;
  localparam int NPH       = 2 * DEF_WIDTH;

  typedef struct packed {
    logic       legal;
    logic [4:0] idx;
  } jc_dec_t;

  // Codes wider than 'width' must arrive zero-extended; only the low 'width' bits may be set.
  function automatic jc_dec_t jc_decode(input logic [MAX_W-1:0] code, input int width);
    jc_dec_t          r;
    logic [MAX_W-1:0] mask;
    logic [MAX_W-1:0] ones;
    r    = '0;
    mask = '0;
    for (int i = 0; i < MAX_W; i++) begin
      if (i < width) mask[i] = 1'b1;
    end
    for (int k = 0; k <= MAX_W; k++) begin
      ones = '0;
      for (int i = 0; i < MAX_W; i++) begin
        if (i < k) ones[i] = 1'b1;
      end
      if ((k <= width) && (code == ones)) begin
        r.legal = 1'b1;
        r.idx   = 5'(k);
      end
      if ((k >= 1) && (k < width) && (code == (mask & ~ones))) begin
        r.legal = 1'b1;
        r.idx   = 5'(width + k);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/johnson_phase_monitor_decode.sv
// Combinational Johnson-code decoder: q -> legal flag, phase index and one-hot phase.
module johnson_decode
  import johnson_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0]           q,
  output logic                       legal,
  output logic [$clog2(2*WIDTH)-1:0] phase_idx,
  output logic [2*WIDTH-1:0]         phase_oh
);

  localparam int IDX_W = $clog2(2 * WIDTH);

  jc_dec_t dec;

  always_comb begin
    dec       = jc_decode(MAX_W'(q), WIDTH);
    legal     = dec.legal;
    phase_idx = IDX_W'(dec.idx);
    phase_oh  = '0;
    if (dec.legal) phase_oh[phase_idx] = 1'b1;
  end

endmodule

// File: rtl/johnson_phase_monitor.sv
// Samples a Johnson counter, decodes its phase, checks every step, tracks lock and
// counts faults with a saturating counter.
module johnson_phase_monitor
  import johnson_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int LOCK_CNT = 8,
  parameter int ERR_W    = 8
) (
  input  logic                       clk,
  input  logic                       clear,
  input  logic [WIDTH-1:0]           q_in,
  input  logic                       clr_err,
  output logic [$clog2(2*WIDTH)-1:0] phase_idx,
  output logic [2*WIDTH-1:0]         phase_oh,
  output logic                       legal,
  output logic                       wrap,
  output logic                       step_err,
  output logic                       locked,
  output logic [ERR_W-1:0]           err_cnt
);

  localparam int PHASES = 2 * WIDTH;
  localparam int IDX_W  = $clog2(PHASES);
  localparam int GOOD_W = $clog2(LOCK_CNT + 1);

  logic [WIDTH-1:0]  q_s;
  logic              s_valid;
  logic              prev_valid;
  logic              dec_legal;
  logic [IDX_W-1:0]  dec_idx;
  logic [IDX_W-1:0]  next_idx;
  logic [PHASES-1:0] dec_oh;
  logic              is_hold;
  logic              is_adv;
  logic              is_bad;
  logic              fault;
  lock_state_t       state;
  lock_state_t       state_nxt;
  logic [GOOD_W-1:0] good;
  logic [GOOD_W-1:0] good_nxt;

  // s_valid keeps the post-reset q_s=0 from being judged as a real sample.
  always_ff @(posedge clk) begin
    if (clear) begin
      q_s     <= '0;
      s_valid <= 1'b0;
    end else begin
      q_s     <= q_in;
      s_valid <= 1'b1;
    end
  end

  johnson_decode #(.WIDTH(WIDTH)) u_decode (
    .q         (q_s),
    .legal     (dec_legal),
    .phase_idx (dec_idx),
    .phase_oh  (dec_oh)
  );

  // phase_idx always holds the last legal phase, so it doubles as the previous phase.
  always_comb begin
    next_idx = (phase_idx == IDX_W'(PHASES - 1)) ? '0 : phase_idx + IDX_W'(1);
    is_hold  = s_valid & dec_legal & prev_valid & (dec_idx == phase_idx);
    is_adv   = s_valid & dec_legal & prev_valid & (dec_idx == next_idx);
    is_bad   = s_valid & dec_legal & prev_valid & ~is_hold & ~is_adv;
    fault    = s_valid & (~dec_legal | is_bad);
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      phase_idx  <= '0;
      phase_oh   <= '0;
      legal      <= 1'b0;
      wrap       <= 1'b0;
      step_err   <= 1'b0;
      prev_valid <= 1'b0;
      err_cnt    <= '0;
    end else begin
      if (clr_err) begin
        err_cnt <= '0;
      end else if (fault && (err_cnt != '1)) begin
        err_cnt <= err_cnt + ERR_W'(1);
      end
      if (s_valid) begin
        legal      <= dec_legal;
        phase_oh   <= dec_oh;
        wrap       <= is_adv & (dec_idx == '0);
        step_err   <= is_bad;
        prev_valid <= dec_legal;
        if (dec_legal) phase_idx <= dec_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state <= SEARCH;
      good  <= '0;
    end else begin
      state <= state_nxt;
      good  <= good_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    good_nxt  = good;
    if (s_valid) begin
      case (state)
        SEARCH: begin
          if (dec_legal) begin
            state_nxt = ACQ;
            good_nxt  = '0;
          end
        end
        ACQ: begin
          if (fault) begin
            state_nxt = SEARCH;
          end else if (is_adv) begin
            if (good == GOOD_W'(LOCK_CNT - 1)) state_nxt = LOCKED;
            else                               good_nxt  = good + GOOD_W'(1);
          end
        end
        LOCKED: begin
          if (fault) state_nxt = LOST;
        end
        LOST:    state_nxt = SEARCH;
        default: state_nxt = SEARCH;
      endcase
    end
  end

  always_comb begin
    locked = (state == LOCKED);
  end

endmodule
